// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one word load/store at a time and answers
// after a fixed LATENCY. Storage is kept across reset; control state is not.
module data_memory_responder #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_write_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);
    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [31:0] data_reg, data_next;
    logic        err_reg, err_next;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-3:0] word_addr;
    logic [IDX_W-1:0]      req_index;
    logic                  req_err;
    logic                  accept;

    // Decode the request address: word index plus alignment/range error.
    assign word_addr = req_address[ADDR_WIDTH-1:2];
    assign req_index = word_addr[IDX_W-1:0];
    assign req_err   = (req_address[1:0] != 2'b00) || (word_addr >= DEPTH_W);

    // Only IDLE accepts; reset also holds off acceptance while asserted.
    assign req_ready  = (state_reg == IDLE) && reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_reg == RESP);
    assign resp_data  = data_reg;
    assign resp_error = err_reg;

    // Storage: stores commit at the accepting edge; never cleared by reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            mem[req_index] <= req_write_data;
        end
    end

    // Control and response registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            data_reg  <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: capture the response at accept, count down, hold until consumed.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    err_next   = req_err;
                    data_next  = (!req_write && !req_err) ? mem[req_index] : 32'd0;
                    count_next = COUNT_INIT;
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                    data_next  = 32'd0;
                    err_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a LATENCY=3 and a LATENCY=1 instance share
// the stimulus, steered by sel; responses are checked against table constants
// and an array-based reference model.
module tb_data_memory_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        resp_ready = 1'b0;
    logic [31:0] req_address = 32'd0;
    logic [31:0] req_write_data = 32'd0;

    logic        rr0, rv0, re0, rr1, rv1, re1;
    logic [31:0] rd0, rd1;
    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_accept = 0;

    logic [31:0] model_mem [2][DEPTH];

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ed;
        bit          ee;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !sel), .req_ready(rr0),
        .req_write(req_write), .req_address(req_address), .req_write_data(req_write_data),
        .resp_valid(rv0), .resp_ready(resp_ready && !sel),
        .resp_data(rd0), .resp_error(re0)
    );

    data_memory_responder #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel), .req_ready(rr1),
        .req_write(req_write), .req_address(req_address), .req_write_data(req_write_data),
        .resp_valid(rv1), .resp_ready(resp_ready && sel),
        .resp_data(rd1), .resp_error(re1)
    );

    assign cur_ready = sel ? rr1 : rr0;
    assign cur_valid = sel ? rv1 : rv0;
    assign cur_data  = sel ? rd1 : rd0;
    assign cur_err   = sel ? re1 : re0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: word-addressed array; errors for misaligned or index >= DEPTH.
    task automatic model_op(input bit w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] ed, output logic ee);
        int s;
        int idx;
        s  = sel ? 1 : 0;
        ee = ((a % 4) != 0) || ((a / 4) >= DEPTH);
        ed = 32'd0;
        if (!ee) begin
            idx = int'(a / 4);
            if (w) model_mem[s][idx] = d;
            else   ed = model_mem[s][idx];
        end
    endtask

    // One transaction; called and returns right after a falling edge.
    task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input int pre, input int stall,
                         output logic [31:0] rd, output logic re, output int lat, output bit ok);
        int n;
        ok = 1'b1;
        rd = 32'd0;
        re = 1'b0;
        lat = 0;
        for (int i = 0; i < pre; i++) begin
            req_valid   = 1'b0;
            req_address = $urandom;
            resp_ready  = 1'($urandom);
            @(negedge clk);
        end
        resp_ready     = 1'b0;
        req_valid      = 1'b1;
        req_write      = w;
        req_address    = a;
        req_write_data = d;
        n = 0;
        while (!cur_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            check("req_ready_timeout", 32'(cur_ready), 32'd1);
            ok = 1'b0;
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        last_accept = cyc;
        // Request inputs are don't-care until the next accept.
        req_valid      = 1'($urandom);
        req_write      = 1'($urandom);
        req_address    = $urandom;
        req_write_data = $urandom;
        lat = 1;
        while (!cur_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!cur_valid) begin
            check("resp_valid_timeout", 32'(cur_valid), 32'd1);
            ok = 1'b0;
            req_valid = 1'b0;
            return;
        end
        rd = cur_data;
        re = cur_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!cur_valid || cur_data !== rd || cur_err !== re || cur_ready) ok = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("post_valid", 32'(cur_valid), 32'd0);
        check("post_ready", 32'(cur_ready), 32'd1);
        check("post_data", cur_data, 32'd0);
        check("post_err", 32'(cur_err), 32'd0);
        $display("op sel=%0d w=%0d addr=%h wdata=%h -> data=%h err=%0d lat=%0d",
                 sel, w, a, d, rd, re, lat);
    endtask

    task automatic run_op(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int pre, input int stall, input string tag);
        logic [31:0] ed, rd;
        logic        ee, re;
        int          lat;
        bit          ok;
        model_op(w, a, d, ed, ee);
        do_op(w, a, d, pre, stall, rd, re, lat, ok);
        check({tag, "_data"}, rd, ed);
        check({tag, "_err"}, 32'(re), 32'(ee));
        check({tag, "_lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
        if (stall > 0) check({tag, "_hold"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic        re;
        int          lat;
        int          prev;
        bit          ok;
        bit          stale;
        logic [31:0] l1_addr [3];

        vecs[0]  = '{1'b1, 32'h0000_00FC, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'h0000_00AB, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_00AB, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_00AB, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0011, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(cur_ready), 32'd0);
        check("rst_resp_valid", 32'(cur_valid), 32'd0);
        check("rst_resp_data", cur_data, 32'd0);
        check("rst_resp_error", 32'(cur_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Give every word of the LATENCY=3 instance a known value
        for (int i = 0; i < DEPTH; i++) begin
            run_op(1'b1, 32'(i * 4), $urandom, 0, 0, "prefill");
        end

        // Directed table
        for (int i = 0; i < 11; i++) begin
            logic [31:0] ed;
            logic        ee;
            model_op(vecs[i].w, vecs[i].a, vecs[i].d, ed, ee);
            do_op(vecs[i].w, vecs[i].a, vecs[i].d, 0, 0, rd, re, lat, ok);
            check($sformatf("vec%0d_data", i), rd, vecs[i].ed);
            check($sformatf("vec%0d_err", i), 32'(re), 32'(vecs[i].ee));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
        end

        // Response held through 5 stalled cycles
        run_op(1'b0, 32'h10, 32'd0, 0, 5, "hold");

        // Reset while a store to 0x20 is in WAIT
        req_valid = 1'b1; req_write = 1'b1; req_address = 32'h20; req_write_data = 32'h55;
        check("rst_pre_ready", 32'(cur_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        model_mem[0][8] = 32'h55;
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(cur_valid), 32'd0);
        check("rst_mid_ready", 32'(cur_ready), 32'd0);
        @(negedge clk);
        check("rst_mid_valid2", 32'(cur_valid), 32'd0);
        check("rst_mid_ready2", 32'(cur_ready), 32'd0);
        reset = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cur_valid) stale = 1'b1;
        end
        check("rst_no_stale", 32'(stale), 32'd0);
        run_op(1'b0, 32'h20, 32'd0, 0, 0, "rst_load");

        // LATENCY=1 instance: back-to-back, accepts every second edge
        sel = 1'b1;
        l1_addr[0] = 32'h0; l1_addr[1] = 32'h4; l1_addr[2] = 32'hFC;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            a = l1_addr[i % 3];
            run_op(i < 3, a, 32'hA500_0000 + 32'(i), 0, 0, "l1");
            if (prev >= 0) check("l1_spacing", 32'(last_accept - prev), 32'd2);
            prev = last_accept;
        end
        sel = 1'b0;
        @(negedge clk);

        // Random traffic against the reference model
        for (int i = 0; i < 1000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else if (r == 1) a = {30'($urandom_range(64, 1000)), 2'b00};
            else             a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            run_op(1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
